// File: rtl/i2c_pkg.sv
// Shared types and widths for the I2C master arbiter.
// Used by i2c_arbiter and its testbench.
package i2c_pkg;

    localparam int I2C_ADDR_W = 7;
    localparam int I2C_DATA_W = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LAUNCH = 2'd1,
        RUN    = 2'd2,
        RESP   = 2'd3
    } arb_state_t;

endpackage

// File: rtl/i2c_rr_pick.sv
// Stateless round-robin picker: first set request after last_served,
// returned as a one-hot vector and as an index.
module i2c_rr_pick #(
    parameter int N_REQ = 4,
    parameter int IDX_W = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] last_served,
    output logic [N_REQ-1:0] winner,
    output logic [IDX_W-1:0] winner_idx
);

    // Scan from farthest to nearest so the nearest set request wins.
    always_comb begin
        int idx;
        winner     = '0;
        winner_idx = '0;
        for (int i = N_REQ; i >= 1; i--) begin
            idx = (int'(last_served) + i) % N_REQ;
            if (req[idx]) begin
                winner      = '0;
                winner[idx] = 1'b1;
                winner_idx  = IDX_W'(idx);
            end
        end
    end

endmodule

// File: rtl/i2c_arbiter.sv
// Round-robin arbiter sharing one single-byte I2C master among N_REQ users.
// Optional launch watchdog enabled by macro I2C_ARBITER_TIMEOUT_EN.
module i2c_arbiter
    import i2c_pkg::*;
#(
    parameter int N_REQ          = 4,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                          i_clk,
    input  logic                          i_rst_n,
    input  logic [N_REQ-1:0]              i_req,
    input  logic [N_REQ*I2C_ADDR_W-1:0]   i_req_addr,
    input  logic [N_REQ-1:0]              i_req_rw,
    input  logic [N_REQ*I2C_DATA_W-1:0]   i_req_wdata,
    output logic [N_REQ-1:0]              o_gnt,
    output logic [N_REQ-1:0]              o_done,
    output logic [I2C_DATA_W-1:0]         o_rd_data,
    output logic                          o_ack_err,
    output logic                          o_timeout_err,
    output logic                          o_m_enable,
    output logic [I2C_ADDR_W-1:0]         o_m_slave_addr,
    output logic                          o_m_rw,
    output logic [I2C_DATA_W-1:0]         o_m_wr_byte,
    input  logic                          i_m_busy,
    input  logic [I2C_DATA_W-1:0]         i_m_rd_byte,
    input  logic                          i_m_ack_error
);

    localparam int IDX_W = $clog2(N_REQ);

    if (N_REQ < 2 || N_REQ > 8 || TIMEOUT_CYCLES < 1) begin : g_bad_cfg
        $error("i2c_arbiter: N_REQ must be 2..8, TIMEOUT_CYCLES >= 1");
    end

    arb_state_t             state_q, state_d;
    logic [N_REQ-1:0]       gnt_q, gnt_d;
    logic [IDX_W-1:0]       idx_q, idx_d;
    logic [IDX_W-1:0]       last_q, last_d;
    logic [I2C_ADDR_W-1:0]  addr_q, addr_d;
    logic                   rw_q, rw_d;
    logic [I2C_DATA_W-1:0]  wr_q, wr_d;
    logic [I2C_DATA_W-1:0]  rd_q, rd_d;
    logic                   ack_q, ack_d;
    logic [N_REQ-1:0]       win_oh;
    logic [IDX_W-1:0]       win_idx;
    logic                   timeout_hit;

    i2c_rr_pick #(
        .N_REQ (N_REQ),
        .IDX_W (IDX_W)
    ) u_pick (
        .req         (i_req),
        .last_served (last_q),
        .winner      (win_oh),
        .winner_idx  (win_idx)
    );

`ifdef I2C_ARBITER_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             to_q, to_d;

    // Busy rising on the last launch cycle still wins over the watchdog.
    assign timeout_hit = (state_q == LAUNCH) && !i_m_busy &&
                         (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

    // Launch-cycle counter and timeout flag, cleared outside LAUNCH/RESP.
    always_comb begin
        cnt_d = (state_q == LAUNCH) ? cnt_q + CNT_W'(1) : '0;
        to_d  = to_q;
        if (timeout_hit) to_d = 1'b1;
        if (state_q == RESP) to_d = 1'b0;
    end

    // Watchdog registers.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            cnt_q <= '0;
            to_q  <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            to_q  <= to_d;
        end
    end

    assign o_timeout_err = to_q;
`else
    assign timeout_hit   = 1'b0;
    assign o_timeout_err = 1'b0;
`endif

    // State register.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) state_q <= IDLE;
        else          state_q <= state_d;
    end

    // Next state; a busy master seen in IDLE blocks any grant.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (|i_req && !i_m_busy) state_d = LAUNCH;
            LAUNCH:  if (i_m_busy)            state_d = RUN;
                     else if (timeout_hit)    state_d = RESP;
            RUN:     if (!i_m_busy)           state_d = RESP;
            RESP:                             state_d = IDLE;
            default:                          state_d = IDLE;
        endcase
    end

    // Datapath: latch winner on grant, capture result at busy fall,
    // retire the grant and rotate priority in RESP.
    always_comb begin
        gnt_d  = gnt_q;
        idx_d  = idx_q;
        last_d = last_q;
        addr_d = addr_q;
        rw_d   = rw_q;
        wr_d   = wr_q;
        rd_d   = rd_q;
        ack_d  = ack_q;
        if (state_q == IDLE && state_d == LAUNCH) begin
            gnt_d  = win_oh;
            idx_d  = win_idx;
            addr_d = i_req_addr[win_idx*I2C_ADDR_W +: I2C_ADDR_W];
            rw_d   = i_req_rw[win_idx];
            wr_d   = i_req_wdata[win_idx*I2C_DATA_W +: I2C_DATA_W];
        end
        if (state_q == RUN && state_d == RESP) begin
            rd_d  = i_m_rd_byte;
            ack_d = i_m_ack_error;
        end
        if (timeout_hit) begin
            rd_d  = '0;
            ack_d = 1'b0;
        end
        if (state_q == RESP) begin
            gnt_d  = '0;
            last_d = idx_q;
            rd_d   = '0;
            ack_d  = 1'b0;
        end
    end

    // Datapath registers.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            gnt_q  <= '0;
            idx_q  <= '0;
            last_q <= IDX_W'(N_REQ - 1);
            addr_q <= '0;
            rw_q   <= 1'b0;
            wr_q   <= '0;
            rd_q   <= '0;
            ack_q  <= 1'b0;
        end else begin
            gnt_q  <= gnt_d;
            idx_q  <= idx_d;
            last_q <= last_d;
            addr_q <= addr_d;
            rw_q   <= rw_d;
            wr_q   <= wr_d;
            rd_q   <= rd_d;
            ack_q  <= ack_d;
        end
    end

    // Outputs decoded from state so reset drops enable at once.
    always_comb begin
        o_gnt          = gnt_q;
        o_done         = (state_q == RESP) ? gnt_q : '0;
        o_m_enable     = (state_q == LAUNCH);
        o_m_slave_addr = addr_q;
        o_m_rw         = rw_q;
        o_m_wr_byte    = wr_q;
        o_rd_data      = rd_q;
        o_ack_err      = ack_q;
    end

endmodule

// File: doc/i2c_arbiter.md
I2C_ARBITER -- requirements
Module: i2c_arbiter

Interface
REQ-001 SHALL have parameter N_REQ, default 4: number of requesters (2..8).
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 1024: maximum i_clk cycles from o_m_enable rise to i_m_busy rise.
REQ-003 SHALL have port i_clk, input, 1: main FPGA clock; the block has one clock.
REQ-004 SHALL have port i_rst_n, input, 1: reset, asynchronous and active-low.
REQ-005 SHALL have port i_req, input, N_REQ: per-requester transaction request, level.
REQ-006 SHALL have port i_req_addr, input, N_REQ*7: per-requester 7-bit slave address, requester k at bits [7k+6:7k].
REQ-007 SHALL have port i_req_rw, input, N_REQ: per-requester direction, 0 = write, 1 = read.
REQ-008 SHALL have port i_req_wdata, input, N_REQ*8: per-requester write byte, requester k at bits [8k+7:8k].
REQ-009 SHALL have port o_gnt, output, N_REQ: one-hot grant, held from grant until done.
REQ-010 SHALL have port o_done, output, N_REQ: one-cycle completion pulse to the granted requester.
REQ-011 SHALL have port o_rd_data, output, 8: read byte, valid in the o_done cycle.
REQ-012 SHALL have port o_ack_err, output, 1: slave NACK flag, valid in the o_done cycle.
REQ-013 SHALL have port o_timeout_err, output, 1: master-never-started flag, valid in the o_done cycle.
REQ-014 SHALL have ports o_m_enable (1), o_m_slave_addr (7), o_m_rw (1) and o_m_wr_byte (8), outputs, driving the I2C master.
REQ-015 SHALL have ports i_m_busy (1), i_m_rd_byte (8) and i_m_ack_error (1), inputs, from the I2C master.

Function
REQ-016 SHALL implement states IDLE, LAUNCH, RUN and RESP.
REQ-017 IDLE: when any i_req is set, SHALL pick the winner round-robin, starting search at (last_served+1) mod N_REQ.
REQ-018 On picking a winner, SHALL latch its addr, rw and wdata into o_m_* registers, set its o_gnt bit and move to LAUNCH on the next edge.
REQ-019 LAUNCH: SHALL hold o_m_enable=1 and move to RUN on the first cycle i_m_busy=1.
REQ-020 RUN: SHALL drive o_m_enable=0 (single-byte transaction) and move to RESP on the first cycle i_m_busy=0.
REQ-021 RESP: SHALL, for exactly one cycle, pulse o_done for the granted requester, present o_rd_data=i_m_rd_byte (registered at the busy fall) and o_ack_err=i_m_ack_error, update last_served, clear o_gnt and return to IDLE.
REQ-022 SHALL keep o_gnt one-hot or zero, and o_done only for the bit set in o_gnt.
REQ-023 A requester dropping i_req after grant SHALL NOT abort the transaction; completion and o_done still occur.
REQ-024 A requester's i_req still set in its RESP cycle SHALL be treated as a new request, re-arbitrated in IDLE with lowest priority.
REQ-025 Minimum back-to-back spacing SHALL be 1 IDLE cycle between o_done and the next o_gnt.
REQ-026 SHALL sample i_m_busy already high in IDLE as "master occupied" and grant nothing until it falls.

Reset
REQ-027 While i_rst_n=0, SHALL asynchronously force state=IDLE, last_served=N_REQ-1, o_gnt=0, o_done=0, o_m_enable=0, o_m_slave_addr=0, o_m_rw=0, o_m_wr_byte=0, o_rd_data=0, o_ack_err=0, o_timeout_err=0 and timeout counter=0.
REQ-028 Reset asserted mid-transaction SHALL drop o_m_enable immediately, with no o_done issued.

Configuration
REQ-029 With macro I2C_ARBITER_TIMEOUT_EN defined, SHALL count cycles in LAUNCH; on reaching TIMEOUT_CYCLES it SHALL go to RESP with o_timeout_err=1, o_ack_err=0, o_rd_data=0 and o_m_enable=0.
REQ-030 Without the macro, SHALL have no counter, SHALL tie o_timeout_err to 0 and SHALL wait in LAUNCH indefinitely.

Structure
REQ-031 SHALL take from package i2c_pkg: state enum arb_state_t, I2C_ADDR_W=7, I2C_DATA_W=8.
REQ-032 SHALL implement round-robin pick in sub-module i2c_rr_pick (inputs req vector and last_served; outputs one-hot winner and its index), with no state.

Verification
REQ-033 Single request: i_req=4'b0010, addr 7'h07, rw=1; model busy high 3 cycles after enable, low 200 cycles later, rd_byte 8'hA5 -> o_gnt=4'b0010, one o_done[1] pulse, o_rd_data=8'hA5, o_ack_err=0.
REQ-034 Contention: i_req=4'b1111 held -> grant order 0,1,2,3,0, each o_done before the next o_gnt.
REQ-035 NACK: model i_m_ack_error=1 at busy fall -> o_ack_err=1 in the o_done cycle only.
REQ-036 Timeout (macro on, TIMEOUT_CYCLES=16): busy never rises -> o_done after 16 LAUNCH cycles, o_timeout_err=1, o_m_enable=0.
REQ-037 Reset mid-RUN: assert i_rst_n=0 -> o_m_enable=0 and o_gnt=0 the same cycle, no o_done; after release, pending i_req=4'b0001 is served first.
